dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
Data-cache responder for the single-cycle core. It services the MemRead/MemWrite requests the control unit raises for lw/sw, and stalls the core until each request completes.
- Organisation: direct-mapped, write-through, no-write-allocate, multi-word lines.
- Read misses fill a whole line from main memory using a req/ready handshake.
- Sits between the core datapath and the main-memory model.

Parameters:
ADDR_W, 32, byte-address width.
DATA_W, 32, word width.
INDEX_W, 4, index bits; the cache has 2^INDEX_W lines.
WOFF_W, 2, word-offset bits; each line holds 2^WOFF_W words.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
MemRead  in  1  core load request.
MemWrite  in  1  core store request.
addr  in  ADDR_W  core byte address.
wdata  in  DATA_W  core store data.
rdata  out  DATA_W  load data; valid when MemRead=1 and stall=0.
stall  out  1  freezes the core PC and pipeline while high.
mem_req  out  1  main-memory request.
mem_we  out  1  1 = write beat, 0 = read beat.
mem_addr  out  ADDR_W  word-aligned memory address.
mem_wdata  out  DATA_W  memory write data.
mem_ready  in  1  memory beat complete; samples or returns one word.
mem_rdata  in  DATA_W  memory read data, valid with mem_ready.

Behaviour:
- Address split:
  - addr[1:0] ignored (accesses treated as word-aligned).
  - word offset = addr[WOFF_W+1:2].
  - index = next INDEX_W bits.
  - tag = remaining upper bits.
- Storage: data array, tag array, valid bits.
- hit = valid[index] & (tag_array[index] == tag).
- Core contract: the core holds MemRead, MemWrite, addr and wdata stable while stall=1.
- Priority: MemWrite has priority if MemRead and MemWrite are both high.
- States: IDLE, FILL, WRITE.
- IDLE:
  - Read hit: rdata = line word, combinational in the same cycle; stall=0; no mem_req.
  - Read miss: stall=1 combinationally. Next edge → FILL; clear valid[index]; beat counter = 0.
  - Write: stall=1 combinationally. Next edge → WRITE.
  - No request: stall=0, mem_req=0.
- FILL:
  - Outputs: mem_req=1, mem_we=0, mem_addr = {tag, index, cnt, 2'b00}, stall=1.
  - On each mem_ready: store mem_rdata into word cnt; cnt++.
  - On mem_ready with cnt = 2^WOFF_W - 1: set valid and tag; → IDLE.
  - The following IDLE cycle hits, so read-miss latency = 2^WOFF_W beats + 2 cycles.
- WRITE:
  - Outputs: mem_req=1, mem_we=1, mem_addr = {addr[ADDR_W-1:2], 2'b00}, mem_wdata = wdata.
  - stall = ~mem_ready.
  - On mem_ready: if hit, update the cached word with wdata (write-through). Write miss leaves the cache unchanged. → IDLE.
  - The core advances on the same edge the write completes.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ready.
  - mem_ready while mem_req=0 is ignored.
  - Each beat takes ≥1 cycle after mem_req rises.
- Reset (asynchronous, any state including mid-FILL or mid-WRITE):
  - State = IDLE, cnt = 0, all valid bits = 0.
  - mem_req=0 and stall=0 immediately.
  - mem_we=0, mem_addr=0, mem_wdata=0, rdata=0.
  - A partially filled line stays invalid.
- Registered mem outputs are zero in IDLE.
- Data and tag arrays need no reset.

Test Plan:
- Reset, then MemRead addr=0x100; memory returns 0xA0..0xA3 with ready after 1 cycle each → 4 read beats at 0x100, 0x104, 0x108, 0x10C; stall high throughout; rdata=0xA0 with stall=0 in the cycle after the last beat.
- Then MemRead addr=0x108 → hit: stall=0 in the same cycle, rdata=0xA2, mem_req stays 0.
- MemWrite addr=0x104, wdata=0xDEADBEEF, ready after 3 cycles → one write beat at 0x104 with mem_we=1; stall high for 3 cycles and low in the ready cycle; subsequent MemRead 0x104 hits with rdata=0xDEADBEEF.
- MemWrite addr=0x200 (write miss) → one memory write beat; MemRead 0x100 still hits (no allocate); MemRead 0x200 misses and fills.
- Conflict: MemRead 0x1100 after 0x100 is resident → miss, fill from 0x1100 to 0x110C; MemRead 0x100 then misses again.
- Assert rst_n=0 after 2 of 4 fill beats → mem_req and stall drop asynchronously; after release, MemRead 0x100 misses and performs a full 4-beat fill.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache for the core.
// Read misses fill a whole line from main memory over a req/ready handshake.
module dcache_controller #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4,
    parameter int WOFF_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int TAG_W = ADDR_W - INDEX_W - WOFF_W - 2;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << (INDEX_W + WOFF_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [WOFF_W-1:0] cnt_q, cnt_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [WORDS];
    logic [TAG_W-1:0]  tag_q  [LINES];

    logic [WOFF_W-1:0]  woff;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               last_beat;
    logic               fill_we;
    logic               upd_we;
    logic               stall_c;
    logic [DATA_W-1:0]  rdata_c;

    assign woff      = addr[WOFF_W+1:2];
    assign idx       = addr[WOFF_W+2 +: INDEX_W];
    assign tag       = addr[ADDR_W-1 -: TAG_W];
    assign hit       = valid_q[idx] & (tag_q[idx] == tag);
    assign last_beat = (cnt_q == {WOFF_W{1'b1}});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        stall_c   = 1'b0;
        rdata_c   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        fill_we   = 1'b0;
        upd_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MemWrite) begin
                    stall_c = 1'b1;
                    state_d = S_WRITE;
                end else if (MemRead) begin
                    if (hit) begin
                        rdata_c = data_q[{idx, woff}];
                    end else begin
                        stall_c      = 1'b1;
                        state_d      = S_FILL;
                        valid_d[idx] = 1'b0;
                        cnt_d        = '0;
                    end
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {tag, idx, cnt_q, 2'b00};
                stall_c  = 1'b1;
                if (mem_ready) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_beat) begin
                        valid_d[idx] = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                // byte offset bits are forced low: accesses are word-aligned
                mem_addr  = addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
                mem_wdata = wdata;
                stall_c   = ~mem_ready;
                if (mem_ready) begin
                    upd_we  = hit;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // reset must drop the core stall at once, even with a request held high
    assign stall = rst_n & stall_c;
    assign rdata = rst_n ? rdata_c : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[{idx, cnt_q}] <= mem_rdata;
        end else if (upd_we) begin
            data_q[{idx, woff}] <= wdata;
        end
        if (fill_we && last_beat) begin
            tag_q[idx] <= tag;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: table of core transactions
// against a main-memory model, plus reset corner sequences.
module tb_dcache_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    dcache_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;
    int dly = 0;
    int w = 0;
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A0000;
    endfunction

    // memory: ready after dly idle cycles of each beat
    always @(posedge clk) begin
        #2;
        mem_ready = 1'b0;
        if (!mem_req) begin
            w = 0;
        end else if (w >= dly) begin
            mem_ready = 1'b1;
            w = 0;
            if (mem_we) mem[mem_addr] = mem_wdata;
            else mem_rdata = rd_mem(mem_addr);
        end else begin
            w++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        int          cyc;
        int          beats;
        logic [31:0] a_first;
        logic [31:0] a_last;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [14];

    task automatic do_op(input vec_t v, output int cyc, output int beats,
                         output int reqc, output logic [31:0] a0,
                         output logic [31:0] an, output logic [31:0] rd,
                         output logic we0);
        bit done = 0;
        cyc = 0; beats = 0; reqc = 0;
        a0 = '0; an = '0; rd = '0; we0 = 1'b0;
        dly = v.dly;
        MemRead = v.rd; MemWrite = v.wr;
        addr = v.addr; wdata = v.wdata;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (mem_req) reqc++;
            if (mem_req && mem_ready) begin
                if (beats == 0) begin
                    a0 = mem_addr;
                    we0 = mem_we;
                end
                an = mem_addr;
                beats++;
            end
            if (!stall) begin
                done = 1;
                rd = rdata;
            end
            @(posedge clk);
            #1;
        end
        MemRead = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int cyc, beats, reqc;
        logic [31:0] a0, an, rd;
        logic we0;
        do_op(v, cyc, beats, reqc, a0, an, rd, we0);
        chk({nm, " cycles"}, cyc, v.cyc);
        chk({nm, " beats"}, beats, v.beats);
        if (v.beats == 0) chk({nm, " req_cycles"}, reqc, 0);
        if (v.beats != 0) begin
            chk({nm, " first_addr"}, a0, v.a_first);
            chk({nm, " last_addr"}, an, v.a_last);
            chk({nm, " we"}, {31'b0, we0}, {31'b0, v.wr});
        end
        if (v.rd && !v.wr) chk({nm, " rdata"}, rd, v.rdata);
    endtask

    initial begin
        int nb;
        vec_t v;
        tbl[0]  = '{1, 0, 32'h100,  0, 0, 6, 4, 32'h100, 32'h10C, 32'hA0};
        tbl[1]  = '{1, 0, 32'h108,  0, 0, 1, 0, 0, 0, 32'hA2};
        tbl[2]  = '{0, 1, 32'h104,  32'hDEADBEEF, 2, 4, 1,
                    32'h104, 32'h104, 0};
        tbl[3]  = '{1, 0, 32'h104,  0, 0, 1, 0, 0, 0, 32'hDEADBEEF};
        tbl[4]  = '{0, 1, 32'h200,  32'h11112222, 0, 2, 1,
                    32'h200, 32'h200, 0};
        tbl[5]  = '{1, 0, 32'h100,  0, 0, 1, 0, 0, 0, 32'hA0};
        tbl[6]  = '{1, 0, 32'h200,  0, 0, 6, 4, 32'h200, 32'h20C,
                    32'h11112222};
        tbl[7]  = '{1, 0, 32'h100,  0, 0, 6, 4, 32'h100, 32'h10C, 32'hA0};
        tbl[8]  = '{1, 0, 32'h104,  0, 0, 1, 0, 0, 0, 32'hDEADBEEF};
        tbl[9]  = '{1, 0, 32'h1100, 0, 0, 6, 4, 32'h1100, 32'h110C,
                    32'h5A5A1100};
        tbl[10] = '{1, 0, 32'h100,  0, 0, 6, 4, 32'h100, 32'h10C, 32'hA0};
        tbl[11] = '{1, 0, 32'h10C,  0, 0, 1, 0, 0, 0, 32'hA3};
        tbl[12] = '{1, 0, 32'h2008, 0, 1, 10, 4, 32'h2000, 32'h200C,
                    32'h5A5A2008};
        tbl[13] = '{1, 1, 32'h30,   32'h33, 0, 2, 1, 32'h30, 32'h30, 0};
        for (int i = 0; i < 4; i++) mem[32'h100 + 4 * i] = 32'hA0 + i;

        // reset with a load held high: outputs must stay quiet
        #1 rst_n = 1'b0;
        MemRead = 1'b1;
        addr = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        chk("rst stall", {31'b0, stall}, 0);
        chk("rst mem_req", {31'b0, mem_req}, 0);
        chk("rst mem_we", {31'b0, mem_we}, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst rdata", rdata, 0);
        MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) run_vec($sformatf("v%0d", i), tbl[i]);

        // reset in the middle of a fill
        dly = 0;
        MemRead = 1'b1;
        addr = 32'h100;
        nb = 0;
        for (int c = 0; c < 20 && nb < 2; c++) begin
            @(negedge clk);
            if (mem_req && mem_ready) nb++;
        end
        chk("midfill beats", nb, 2);
        @(posedge clk);
        #1;
        chk("midfill req_before", {31'b0, mem_req}, 1);
        rst_n = 1'b0;
        #1;
        chk("midfill rst mem_req", {31'b0, mem_req}, 0);
        chk("midfill rst stall", {31'b0, stall}, 0);
        chk("midfill rst mem_addr", mem_addr, 0);
        MemRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = '{1, 0, 32'h100, 0, 0, 6, 4, 32'h100, 32'h10C, 32'hA0};
        run_vec("postrst", v);
        v = '{1, 0, 32'h108, 0, 0, 1, 0, 0, 0, 32'hA2};
        run_vec("postrst_hit", v);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
